// File: rtl/add16_accum.sv
// Streaming frame accumulator behind a 16-bit adder: sums LEN operands into {carry count, low word}.
// Optional macro ACC_SAT_EN: saturate {hi, lo} to all ones on carry-counter overflow instead of wrapping.
module add16_accum #(
    parameter int unsigned DW  = 16,
    parameter int unsigned CW  = 8,
    parameter int unsigned LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW+CW-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int unsigned CNTW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     lo_q, lo_d;
    logic [CW-1:0]     hi_q, hi_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [DW:0]       add_w;
    logic              co;
    logic              hi_full;
    logic              last;

    // Next-state and datapath; clr overrides everything except the post-reset IDLE cycle.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        add_w   = {1'b0, lo_q} + {1'b0, in_data};
        co      = add_w[DW];
        hi_full = &hi_q;
        last    = (cnt_q == CNTW'(LEN - 1));

        unique case (state_q)
            S_IDLE: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CNTW'(1);
`ifdef ACC_SAT_EN
                    if (!ovf_q) begin
                        if (co && hi_full) begin
                            lo_d  = '1;
                            hi_d  = '1;
                            ovf_d = 1'b1;
                        end else begin
                            lo_d = add_w[DW-1:0];
                            hi_d = hi_q + CW'(co);
                        end
                    end
`else
                    lo_d = add_w[DW-1:0];
                    hi_d = hi_q + CW'(co);
                    if (co && hi_full) begin
                        ovf_d = 1'b1;
                    end
`endif
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    lo_d    = '0;
                    hi_d    = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clr && (state_q != S_IDLE)) begin
            lo_d    = '0;
            hi_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_ACC;
        end

        in_ready_d  = (state_d == S_ACC);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = {hi_q, lo_q};
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add16_accum.sv
// Bench for add16_accum: two instances (LEN=4/CW=8 and LEN=8/CW=2) checked every cycle against a frame-total model.
module tb_add16_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_ready = 1'b0;

    logic        rdy_a, vld_a, ovf_a;
    logic [23:0] sum_a;
    logic        rdy_b, vld_b, ovf_b;
    logic [17:0] sum_b;

`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    add16_accum #(.DW(16), .CW(8), .LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .out_valid(vld_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_ovf(ovf_a)
    );

    add16_accum #(.DW(16), .CW(2), .LEN(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .out_valid(vld_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_ovf(ovf_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 = waiting after reset, 1 = collecting, 2 = result held; tot is the plain frame total.
    int     ph[2];
    longint tot[2];
    int     n[2];
    int     nph[2];
    longint ntot[2];
    int     nn[2];

    function automatic int len_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int sw_of(input int i);
        return (i == 0) ? 24 : 18;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; tot[i] = 0; n[i] = 0;
        end
    endtask

    task automatic model_next();
        for (int i = 0; i < 2; i++) begin
            nph[i] = ph[i]; ntot[i] = tot[i]; nn[i] = n[i];
            if (!rst_n) begin
                nph[i] = 0; ntot[i] = 0; nn[i] = 0;
            end else if (ph[i] == 0) begin
                nph[i] = 1;
            end else if (clr) begin
                nph[i] = 1; ntot[i] = 0; nn[i] = 0;
            end else if (ph[i] == 1 && in_valid) begin
                ntot[i] = tot[i] + longint'(in_data);
                nn[i] = n[i] + 1;
                if (nn[i] == len_of(i)) nph[i] = 2;
            end else if (ph[i] == 2 && out_ready) begin
                nph[i] = 1; ntot[i] = 0; nn[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        longint full, es;
        logic [63:0] a_sum;
        logic a_rdy, a_vld, a_ovf;
        for (int i = 0; i < 2; i++) begin
            full = (longint'(1) <<< sw_of(i)) - 1;
            if (tot[i] > full) es = SAT ? full : (tot[i] & full);
            else               es = tot[i];
            if (i == 0) begin
                a_rdy = rdy_a; a_vld = vld_a; a_ovf = ovf_a; a_sum = 64'(sum_a);
            end else begin
                a_rdy = rdy_b; a_vld = vld_b; a_ovf = ovf_b; a_sum = 64'(sum_b);
            end
            chk($sformatf("in_ready[%0d]", i), 64'(a_rdy), 64'(ph[i] == 1));
            chk($sformatf("out_valid[%0d]", i), 64'(a_vld), 64'(ph[i] == 2));
            chk($sformatf("out_sum[%0d]", i), a_sum, 64'(es));
            chk($sformatf("out_ovf[%0d]", i), 64'(a_ovf), 64'(tot[i] > full));
        end
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            ph[i] = nph[i]; tot[i] = ntot[i]; n[i] = nn[i];
        end
        compare_all();
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        in_valid = 1'b0;
        cycle();
        clr = 1'b0;
    endtask

    logic [23:0] held;

    initial begin
        model_reset();
        // Reset held low for 3 cycles with in_valid asserted
        in_valid = 1'b1;
        in_data  = 16'h1234;
        #1;
        compare_all();
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_in_ready", 64'(rdy_a), 64'h0);
        chk("rst_out_sum", 64'(sum_a), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_c1_in_ready", 64'(rdy_a), 64'h0);
        in_valid = 1'b0;
        cycle();
        chk("rel_c2_in_ready", 64'(rdy_a), 64'h1);

        // Basic frame
        out_ready = 1'b1;
        feed(16'd1); feed(16'd2); feed(16'd3); feed(16'd4);
        chk("basic_valid", 64'(vld_a), 64'h1);
        chk("basic_sum", 64'(sum_a), 64'h00000A);
        chk("basic_ovf", 64'(ovf_a), 64'h0);
        in_valid = 1'b0;
        cycle();
        chk("basic_valid_1cyc", 64'(vld_a), 64'h0);

        // Carry counting
        do_clr();
        for (int k = 0; k < 4; k++) feed(16'hFFFF);
        chk("carry_sum", 64'(sum_a), 64'h03FFFC);
        chk("carry_ovf", 64'(ovf_a), 64'h0);
        in_valid = 1'b0;

        // Backpressure
        do_clr();
        out_ready = 1'b0;
        feed(16'd1); feed(16'd2); feed(16'd3); feed(16'd4);
        held = sum_a;
        chk("bp_first", 64'(held), 64'h00000A);
        for (int k = 0; k < 5; k++) begin
            feed(16'd7);
            chk("bp_sum_stable", 64'(sum_a), 64'(held));
            chk("bp_in_ready", 64'(rdy_a), 64'h0);
        end
        out_ready = 1'b1;
        feed(16'd7);
        chk("bp_after_hs", 64'(sum_a), 64'h0);
        for (int k = 0; k < 4; k++) feed(16'd7);
        chk("bp_next_frame", 64'(sum_a), 64'h00001C);
        in_valid = 1'b0;

        // Overflow on the CW=2, LEN=8 instance
        do_clr();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) feed(16'hFFFF);
        chk("ovf_valid", 64'(vld_b), 64'h1);
        chk("ovf_sum", 64'(sum_b), SAT ? 64'h3FFFF : 64'h3FFF8);
        chk("ovf_flag", 64'(ovf_b), 64'h1);
        in_valid = 1'b0;

        // Mid-frame abort with clr
        do_clr();
        feed(16'd9); feed(16'd9);
        clr = 1'b1;
        feed(16'd9);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) feed(16'd5);
        chk("abort_clr_sum", 64'(sum_a), 64'h000014);
        in_valid = 1'b0;

        // Mid-frame abort with asynchronous reset
        do_clr();
        feed(16'd9); feed(16'd9);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("abort_rst_async", 64'(sum_a), 64'h0);
        in_valid = 1'b1;
        in_data  = 16'd5;
        cycle(); cycle();
        rst_n = 1'b1;
        #1;
        compare_all();
        cycle();
        chk("abort_rst_noacc", 64'(sum_a), 64'h0);
        for (int k = 0; k < 4; k++) feed(16'd5);
        chk("abort_rst_sum", 64'(sum_a), 64'h000014);
        chk("abort_rst_valid", 64'(vld_a), 64'h1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            clr       = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0)
                in_data = 16'hFFFF - 16'($urandom_range(0, 15));
            else
                in_data = 16'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
